cpu_trace_monitor: RTL and testbench

- Synthesizable, parametrised execution-trace unit that sits beside the CPU core and taps the program counter, instruction word and NZCV flags on every retire strobe.
- Captures retired instructions into a circular buffer and triggers on PC breakpoints.
- Collects a programmable number of post-trigger entries, then raises a halt request.
- Replaces ad-hoc simulation printing with hardware-readable trace history, usable in simulation and on silicon.

---
 rtl/cpu_trace_monitor_if.sv | 15 +
 rtl/cpu_trace_monitor.sv | 204 ++++++++++++++++++++
 tb/tb_cpu_trace_monitor.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_trace_monitor_if.sv
// Retire-side bus from the CPU core into the trace monitor.
// The core drives it as master; the monitor only observes it.
interface cpu_trace_monitor_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16,
  parameter int FLAG_WIDTH  = 4
);
  logic [PC_WIDTH-1:0]    pc_counter;
  logic [INSTR_WIDTH-1:0] instruction;
  logic [FLAG_WIDTH-1:0]  flags;
  logic                   valid;

  modport master (output pc_counter, instruction, flags, valid);
  modport slave  (input  pc_counter, instruction, flags, valid);
endinterface

// File: rtl/cpu_trace_monitor.sv
// Execution-trace unit: circular capture of retired instructions, PC breakpoint
// trigger, post-trigger window and halt request, with a registered read port.
module cpu_trace_monitor #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16,
  parameter int FLAG_WIDTH  = 4,
  parameter int DEPTH       = 16,
  parameter int NUM_BP      = 2,
  parameter int POST_TRIG   = 4,
  localparam int AW         = $clog2(DEPTH),
  localparam int DW         = PC_WIDTH + INSTR_WIDTH + FLAG_WIDTH
) (
  input  logic                       clk,
  input  logic                       pc_reset,
  cpu_trace_monitor_if.slave         retire,
  input  logic                       arm,
  input  logic                       clear,
  input  logic [NUM_BP*PC_WIDTH-1:0] bp_addr,
  input  logic [NUM_BP-1:0]          bp_en,
  input  logic [AW-1:0]              rd_addr,
  output logic [DW-1:0]              rd_data,
  output logic [1:0]                 state,
  output logic                       triggered,
  output logic                       halt_req,
  output logic [AW:0]                entry_count,
  output logic [AW-1:0]              trig_index,
  output logic [15:0]                cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_POST  = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic [AW:0]   COUNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] POST_INIT  = AW'(POST_TRIG);
  localparam bit            POST_ZERO  = (POST_TRIG == 0);

  state_t        state_reg, state_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW:0]   entry_count_reg, entry_count_next;
  logic [AW-1:0] trig_index_reg, trig_index_next;
  logic [AW-1:0] post_cnt_reg, post_cnt_next;
  logic [15:0]   cycle_count_reg, cycle_count_next;
  logic          triggered_reg, triggered_next;

  logic [AW:0]   count_inc;
  logic          wr_en;
  logic          mem_we;
  logic [DW-1:0] wr_data;

  // Breakpoint comparators, one per slice of bp_addr
  logic [NUM_BP-1:0] bp_match;
  logic              bp_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BP; gi++) begin : g_bp
      assign bp_match[gi] = bp_en[gi] &&
                            (retire.pc_counter == bp_addr[gi*PC_WIDTH +: PC_WIDTH]);
    end
  endgenerate

  assign bp_hit  = retire.valid && (|bp_match);
  assign wr_data = {retire.pc_counter, retire.instruction, retire.flags};

  always_comb begin
    state_next       = state_reg;
    wr_ptr_next      = wr_ptr_reg;
    entry_count_next = entry_count_reg;
    trig_index_next  = trig_index_reg;
    post_cnt_next    = post_cnt_reg;
    cycle_count_next = cycle_count_reg;
    triggered_next   = triggered_reg;
    wr_en            = 1'b0;
    count_inc        = (entry_count_reg == COUNT_FULL) ? entry_count_reg
                                                       : entry_count_reg + (AW+1)'(1);

    if (clear) begin
      state_next       = S_IDLE;
      wr_ptr_next      = '0;
      entry_count_next = '0;
      trig_index_next  = '0;
      post_cnt_next    = '0;
      cycle_count_next = '0;
      triggered_next   = 1'b0;
    end else begin
      unique case (state_reg)
        S_IDLE: begin
          if (arm) begin
            state_next       = S_ARMED;
            wr_ptr_next      = '0;
            entry_count_next = '0;
            triggered_next   = 1'b0;
            cycle_count_next = '0;
          end
        end

        S_ARMED: begin
          cycle_count_next = cycle_count_reg + 16'd1;
          if (retire.valid) begin
            wr_en            = 1'b1;
            wr_ptr_next      = wr_ptr_reg + AW'(1);
            entry_count_next = count_inc;
            if (bp_hit) begin
              // Trigger entry is the newest one just written
              triggered_next  = 1'b1;
              trig_index_next = AW'(count_inc - (AW+1)'(1));
              post_cnt_next   = POST_INIT;
              state_next      = POST_ZERO ? S_DONE : S_POST;
            end
          end
        end

        S_POST: begin
          cycle_count_next = cycle_count_reg + 16'd1;
          if (retire.valid) begin
            wr_en            = 1'b1;
            wr_ptr_next      = wr_ptr_reg + AW'(1);
            entry_count_next = count_inc;
            post_cnt_next    = post_cnt_reg - AW'(1);
            // Overwriting the oldest entry shifts the trigger one slot older
            if ((entry_count_reg == COUNT_FULL) && (trig_index_reg != '0)) begin
              trig_index_next = trig_index_reg - AW'(1);
            end
            if (post_cnt_reg == AW'(1)) begin
              state_next = S_DONE;
            end
          end
        end

        S_DONE: begin
          state_next = S_DONE;
        end

        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!pc_reset) begin
      state_reg       <= S_IDLE;
      wr_ptr_reg      <= '0;
      entry_count_reg <= '0;
      trig_index_reg  <= '0;
      post_cnt_reg    <= '0;
      cycle_count_reg <= '0;
      triggered_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      wr_ptr_reg      <= wr_ptr_next;
      entry_count_reg <= entry_count_next;
      trig_index_reg  <= trig_index_next;
      post_cnt_reg    <= post_cnt_next;
      cycle_count_reg <= cycle_count_next;
      triggered_reg   <= triggered_next;
    end
  end

  // Trace storage: plain array with registered read so it maps onto block RAM.
  // Reads see the pre-write contents when both hit the same slot.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_raw_reg;
  logic          rd_kill_reg;
  logic [AW-1:0] rd_phys;
  logic          rd_in_range;

  assign mem_we      = wr_en && pc_reset;
  assign rd_phys     = wr_ptr_reg - entry_count_reg[AW-1:0] + rd_addr;
  assign rd_in_range = ({1'b0, rd_addr} < entry_count_reg);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    rd_raw_reg <= mem[rd_phys];
  end

  // Masking flag keeps unwritten or out-of-window slots from reaching rd_data
  always_ff @(posedge clk) begin
    if (!pc_reset) begin
      rd_kill_reg <= 1'b1;
    end else begin
      rd_kill_reg <= !rd_in_range;
    end
  end

  assign rd_data     = rd_kill_reg ? '0 : rd_raw_reg;
  assign state       = state_reg;
  assign triggered   = triggered_reg;
  assign halt_req    = (state_reg == S_DONE);
  assign entry_count = entry_count_reg;
  assign trig_index  = trig_index_reg;
  assign cycle_count = cycle_count_reg;

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Directed bench for cpu_trace_monitor at default parameters; expected values
// are hand-derived from the retire sequences driven below.
module tb_cpu_trace_monitor;

  logic        clk;
  logic        pc_reset;
  logic        arm;
  logic        clear;
  logic [15:0] bp_addr;
  logic [1:0]  bp_en;
  logic [3:0]  rd_addr;
  logic [27:0] rd_data;
  logic [1:0]  state;
  logic        triggered;
  logic        halt_req;
  logic [4:0]  entry_count;
  logic [3:0]  trig_index;
  logic [15:0] cycle_count;

  int vectors;
  int miscompares;

  cpu_trace_monitor_if #(.PC_WIDTH(8), .INSTR_WIDTH(16), .FLAG_WIDTH(4)) retire_bus ();

  cpu_trace_monitor dut (
    .clk         (clk),
    .pc_reset    (pc_reset),
    .retire      (retire_bus),
    .arm         (arm),
    .clear       (clear),
    .bp_addr     (bp_addr),
    .bp_en       (bp_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .state       (state),
    .triggered   (triggered),
    .halt_req    (halt_req),
    .entry_count (entry_count),
    .trig_index  (trig_index),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end else begin
      $display("ok   %s = 0x%0h", tag, actual);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [27:0] exp_entry(input logic [7:0] pc);
    logic [15:0] instr;
    logic [3:0]  flg;
    instr = 16'hA000 | {8'h00, pc};
    flg   = pc[3:0] ^ 4'h5;
    return {pc, instr, flg};
  endfunction

  task automatic retire(input logic [7:0] pc);
    logic [27:0] e;
    e = exp_entry(pc);
    retire_bus.pc_counter  = pc;
    retire_bus.instruction = e[19:4];
    retire_bus.flags       = e[3:0];
    retire_bus.valid       = 1'b1;
    tick();
    retire_bus.valid       = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors                = 0;
    miscompares            = 0;
    pc_reset               = 1'b0;
    arm                    = 1'b0;
    clear                  = 1'b0;
    bp_addr                = '0;
    bp_en                  = '0;
    rd_addr                = '0;
    retire_bus.pc_counter  = '0;
    retire_bus.instruction = '0;
    retire_bus.flags       = '0;
    retire_bus.valid       = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_state", 32'(state), 32'h0);
    check("rst_triggered", 32'(triggered), 32'h0);
    check("rst_halt", 32'(halt_req), 32'h0);
    check("rst_count", 32'(entry_count), 32'h0);
    check("rst_trig_index", 32'(trig_index), 32'h0);
    check("rst_cycles", 32'(cycle_count), 32'h0);
    check("rst_rd_data", 32'(rd_data), 32'h0);
    pc_reset = 1'b1;

    // 1: five retires, no breakpoint
    do_arm();
    check("t1_armed", 32'(state), 32'h1);
    check("t1_cycles_at_arm", 32'(cycle_count), 32'h0);
    for (int i = 0; i < 5; i++) retire(8'(i));
    check("t1_state", 32'(state), 32'h1);
    check("t1_count", 32'(entry_count), 32'h5);
    check("t1_cycles", 32'(cycle_count), 32'h5);
    rd_addr = 4'd0;
    tick();
    check("t1_rd0", 32'(rd_data), 32'(exp_entry(8'd0)));
    rd_addr = 4'd7;
    tick();
    check("t1_rd7_empty", 32'(rd_data), 32'h0);

    // 2: bp0=8, trigger then 4 post entries
    do_clear();
    bp_addr = {8'd0, 8'd8};
    bp_en   = 2'b01;
    do_arm();
    for (int i = 0; i < 20; i++) retire(8'(i));
    check("t2_state", 32'(state), 32'h3);
    check("t2_halt", 32'(halt_req), 32'h1);
    check("t2_triggered", 32'(triggered), 32'h1);
    check("t2_count", 32'(entry_count), 32'd13);
    check("t2_trig_index", 32'(trig_index), 32'd8);
    check("t2_cycles_frozen", 32'(cycle_count), 32'd13);
    rd_addr = 4'd12;
    tick();
    check("t2_rd12", 32'(rd_data), 32'(exp_entry(8'd12)));
    do_arm();
    check("t2_arm_in_done", 32'(state), 32'h3);

    // 3: no breakpoint, buffer wraps; read-before-write on the oldest slot
    do_clear();
    bp_en   = 2'b00;
    rd_addr = 4'd0;
    do_arm();
    for (int i = 0; i < 20; i++) begin
      retire(8'(i));
      if (i == 16) check("t3_read_old_on_write", 32'(rd_data), 32'(exp_entry(8'd0)));
    end
    check("t3_state", 32'(state), 32'h1);
    check("t3_triggered", 32'(triggered), 32'h0);
    check("t3_count_sat", 32'(entry_count), 32'd16);
    rd_addr = 4'd0;
    tick();
    check("t3_rd0", 32'(rd_data), 32'(exp_entry(8'd4)));
    rd_addr = 4'd15;
    tick();
    check("t3_rd15", 32'(rd_data), 32'(exp_entry(8'd19)));

    // 4: two breakpoints, only the first hit counts
    do_clear();
    bp_addr = {8'd5, 8'd3};
    bp_en   = 2'b11;
    do_arm();
    for (int i = 0; i <= 10; i++) retire(8'(i));
    check("t4_state", 32'(state), 32'h3);
    check("t4_trig_index", 32'(trig_index), 32'd3);
    check("t4_count", 32'(entry_count), 32'd8);
    rd_addr = 4'd7;
    tick();
    check("t4_rd_last", 32'(rd_data), 32'(exp_entry(8'd7)));

    // 5: clear beats arm while in POST; bp1 slice 0 stays disabled
    do_clear();
    bp_addr = {8'd0, 8'd8};
    bp_en   = 2'b01;
    do_arm();
    for (int i = 0; i < 10; i++) retire(8'(i));
    check("t5_post", 32'(state), 32'h2);
    clear = 1'b1;
    arm   = 1'b1;
    tick();
    clear = 1'b0;
    check("t5_clear_state", 32'(state), 32'h0);
    check("t5_clear_halt", 32'(halt_req), 32'h0);
    check("t5_clear_triggered", 32'(triggered), 32'h0);
    tick();
    arm = 1'b0;
    check("t5_rearm_state", 32'(state), 32'h1);
    check("t5_rearm_count", 32'(entry_count), 32'h0);
    check("t5_rearm_cycles", 32'(cycle_count), 32'h0);

    // 6: reset mid-POST with a matching retire on the reset edge
    for (int i = 0; i < 10; i++) retire(8'(i));
    check("t6_post", 32'(state), 32'h2);
    pc_reset = 1'b0;
    retire(8'd8);
    pc_reset = 1'b1;
    check("t6_state", 32'(state), 32'h0);
    check("t6_triggered", 32'(triggered), 32'h0);
    check("t6_halt", 32'(halt_req), 32'h0);
    check("t6_count", 32'(entry_count), 32'h0);
    check("t6_trig_index", 32'(trig_index), 32'h0);
    check("t6_cycles", 32'(cycle_count), 32'h0);
    check("t6_rd_data", 32'(rd_data), 32'h0);
    do_arm();
    retire(8'h55);
    check("t6_count_after", 32'(entry_count), 32'h1);
    rd_addr = 4'd0;
    tick();
    check("t6_rd_first", 32'(rd_data), 32'(exp_entry(8'h55)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
